gate_lane_arbiter: RTL and testbench
====================================

// Module: gate_lane_arbiter
// PURPOSE
//  Shares one parking barrier between N access lanes. Each lane's access controller raises a
//  request once its PIN is accepted. This block grants the barrier round-robin and sequences the
//  motor: open, wait for the vehicle to pass, close. It enforces motor and passage timeouts and
//  raises a sticky motor fault. It sits between the per-lane access FSMs and the barrier drive.
// PARAMETERS
//  N_CARRILES  2    number of requesting lanes (>=2)
//  T_MOTOR     50   max cycles for an open/close travel before fault
//  T_PASO      200  max cycles in ABIERTA waiting for the vehicle before auto-close
// PORTS
//  clock            in   1  single system clock, rising edge
//  reset            in   1  synchronous, active-high
//  solicitud        in   N  per-lane barrier request (level)
//  bloqueo          in   N  per-lane lock alarm; masks that lane's request
//  sensor_abierta   in   1  barrier fully open
//  sensor_cerrada   in   1  barrier fully closed
//  sensor_paso      in   1  vehicle present under barrier
//  concesion        out  N  one-hot grant, held for the whole cycle of use
//  motor_abrir      out  1  open drive
//  motor_cerrar     out  1  close drive
//  fin_paso         out  N  one-cycle pulse on the granted lane when the vehicle has passed
//  falla_motor      out  1  sticky fault flag
// BEHAVIOUR
//  - Reset (sync): state=REPOSO, timer=0, RR pointer=lane 0, all outputs 0.
//  - States, one-hot 6-bit: REPOSO, ABRIENDO, ABIERTA, PASANDO, CERRANDO, FALLA.
//  - Outputs are Moore outputs from the registered state; motor_abrir and motor_cerrar are never both 1.
//  - REPOSO: eligible = solicitud & ~bloqueo. If eligible != 0:
//      - grant the first eligible lane at or after the pointer (wrap-around);
//      - latch it and go to ABRIENDO.
//      Request seen at cycle t -> concesion and motor_abrir high at t+1.
//  - ABRIENDO: motor_abrir=1.
//      - sensor_abierta -> ABIERTA, timer cleared.
//      - timer==T_MOTOR-1 -> FALLA.
//  - ABIERTA: motors off.
//      - sensor_paso -> PASANDO.
//      - timer==T_PASO-1 -> CERRANDO, no fin_paso.
//  - PASANDO: motors off. sensor_paso falls -> CERRANDO; fin_paso[grant] pulses in that
//    transition cycle (one cycle only).
//  - CERRANDO: motor_cerrar=1.
//      - sensor_paso=1 -> ABRIENDO (safety reopen, same grant, timer cleared); this has priority.
//      - sensor_cerrada -> REPOSO; concesion drops; pointer = granted lane+1 mod N.
//      - timer==T_MOTOR-1 -> FALLA.
//  - FALLA: concesion=0, motors off, falla_motor=1; exits only on reset.
//  - Sensor conflict: sensor_abierta & sensor_cerrada both 1 in ABRIENDO or CERRANDO -> FALLA.
//  - Timer: single counter, cleared on every state change; width clog2(max(T_MOTOR,T_PASO)+1).
//    It saturates and never wraps.
//  - Mid-cycle events: once granted, a request drop or bloqueo on the granted lane does not
//    abort the cycle. New requests are only sampled in REPOSO.
//  - Reset asserted in any state: next cycle is REPOSO with motors off. No close is attempted.
// STRUCTURE
//  - Shared package access_pkg: one-hot state localparams (6-bit) and common timeout defaults,
//    reused with the access FSM.
//  - One sub-module, rr_arbiter #(N):
//      - inputs: eligible, pointer;
//      - output: one-hot grant (combinational).
//  - The FSM, timer and pointer live in the top module.
// TESTING
//  1 Reset mid-ABRIENDO -> next cycle motor_abrir=0, concesion=0, state REPOSO, pointer=0.
//  2 solicitud=2'b11 repeated full cycles -> grants alternate 01,10,01; fin_paso matches the grant.
//  3 solicitud=2'b01, bloqueo=2'b01 -> no grant. Then bloqueo=0 -> concesion=01 one cycle later.
//  4 sensor_paso rises in CERRANDO -> motor_cerrar=0, motor_abrir=1 next cycle; grant unchanged.
//  5 No sensor_abierta for 50 cycles -> falla_motor=1 and stays 1 with requests present.
//    Only reset clears it.
//  6 Vehicle never arrives -> after 200 cycles in ABIERTA: CERRANDO, fin_paso stays 0.

Source files
------------

// File: rtl/access_pkg.sv
// Shared definitions for the lane access FSM and the barrier arbiter:
// one-hot state codes and default timeouts.
package access_pkg;

  localparam logic [5:0] ST_REPOSO   = 6'b000001;
  localparam logic [5:0] ST_ABRIENDO = 6'b000010;
  localparam logic [5:0] ST_ABIERTA  = 6'b000100;
  localparam logic [5:0] ST_PASANDO  = 6'b001000;
  localparam logic [5:0] ST_CERRANDO = 6'b010000;
  localparam logic [5:0] ST_FALLA    = 6'b100000;

  typedef enum logic [5:0] {
    REPOSO   = ST_REPOSO,
    ABRIENDO = ST_ABRIENDO,
    ABIERTA  = ST_ABIERTA,
    PASANDO  = ST_PASANDO,
    CERRANDO = ST_CERRANDO,
    FALLA    = ST_FALLA
  } estado_t;

  localparam int unsigned T_MOTOR_DEF = 50;
  localparam int unsigned T_PASO_DEF  = 200;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first eligible lane at or after the pointer, with wrap-around.
// Purely combinational, one-hot result.
module rr_arbiter #(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0]         eligible,
  input  logic [$clog2(N)-1:0] pointer,
  output logic [N-1:0]         grant
);

  localparam int unsigned IW = $clog2(N);

  logic [IW:0]   sum;
  logic [IW-1:0] idx;
  logic          found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      sum = {1'b0, pointer} + (IW+1)'(i);
      if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
      idx = IW'(sum);
      if (!found && eligible[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gate_lane_arbiter.sv
// Shares one parking barrier between lanes: round-robin grant, open/pass/close
// sequencing, motor and passage timeouts, sticky motor fault.
module gate_lane_arbiter
  import access_pkg::*;
#(
  parameter int unsigned N_CARRILES = 2,
  parameter int unsigned T_MOTOR    = T_MOTOR_DEF,
  parameter int unsigned T_PASO     = T_PASO_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [N_CARRILES-1:0] solicitud,
  input  logic [N_CARRILES-1:0] bloqueo,
  input  logic                  sensor_abierta,
  input  logic                  sensor_cerrada,
  input  logic                  sensor_paso,
  output logic [N_CARRILES-1:0] concesion,
  output logic                  motor_abrir,
  output logic                  motor_cerrar,
  output logic [N_CARRILES-1:0] fin_paso,
  output logic                  falla_motor
);

  localparam int unsigned PW   = $clog2(N_CARRILES);
  localparam int unsigned TMAX = max_u(T_MOTOR, T_PASO);
  localparam int unsigned TW   = $clog2(TMAX + 1);

  estado_t               state_q, state_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [PW-1:0]         ptr_q, ptr_d, ptr_next, gidx;
  logic [N_CARRILES-1:0] eligible, arb_grant, grant_d, fin_d;
  logic                  conflict;

  assign eligible = solicitud & ~bloqueo;
  assign conflict = sensor_abierta & sensor_cerrada;

  rr_arbiter #(.N(N_CARRILES)) u_rr (
    .eligible (eligible),
    .pointer  (ptr_q),
    .grant    (arb_grant)
  );

  // Lane after the current grant becomes the next round-robin start.
  always_comb begin
    gidx = '0;
    for (int i = 0; i < N_CARRILES; i++) begin
      if (concesion[i]) gidx = PW'(i);
    end
    ptr_next = (gidx == PW'(N_CARRILES - 1)) ? '0 : gidx + PW'(1);
  end

  always_comb begin
    state_d = state_q;
    grant_d = concesion;
    ptr_d   = ptr_q;
    fin_d   = '0;
    timer_d = timer_q;
    unique case (state_q)
      REPOSO: begin
        grant_d = '0;
        if (|eligible) begin
          grant_d = arb_grant;
          state_d = ABRIENDO;
        end
      end
      ABRIENDO: begin
        if (conflict)                            state_d = FALLA;
        else if (sensor_abierta)                 state_d = ABIERTA;
        else if (timer_q == TW'(T_MOTOR - 1))    state_d = FALLA;
      end
      ABIERTA: begin
        if (sensor_paso)                         state_d = PASANDO;
        else if (timer_q == TW'(T_PASO - 1))     state_d = CERRANDO;
      end
      PASANDO: begin
        if (!sensor_paso) begin
          state_d = CERRANDO;
          fin_d   = concesion;
        end
      end
      CERRANDO: begin
        // Vehicle under the barrier while closing forces a reopen.
        if (conflict)                            state_d = FALLA;
        else if (sensor_paso)                    state_d = ABRIENDO;
        else if (sensor_cerrada) begin
          state_d = REPOSO;
          ptr_d   = ptr_next;
        end
        else if (timer_q == TW'(T_MOTOR - 1))    state_d = FALLA;
      end
      FALLA:   state_d = FALLA;
      default: state_d = REPOSO;
    endcase

    if (state_d == REPOSO || state_d == FALLA) grant_d = '0;

    if (state_d != state_q)            timer_d = '0;
    else if (timer_q != TW'(TMAX))     timer_d = timer_q + TW'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= REPOSO;
      timer_q      <= '0;
      ptr_q        <= '0;
      concesion    <= '0;
      motor_abrir  <= 1'b0;
      motor_cerrar <= 1'b0;
      fin_paso     <= '0;
      falla_motor  <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      ptr_q        <= ptr_d;
      concesion    <= grant_d;
      motor_abrir  <= (state_d == ABRIENDO);
      motor_cerrar <= (state_d == CERRANDO);
      fin_paso     <= fin_d;
      falla_motor  <= (state_d == FALLA);
    end
  end

endmodule

// File: tb/tb_gate_lane_arbiter.sv
// Bench for gate_lane_arbiter: directed scenarios plus random sensor/request traffic,
// every cycle compared against a phase-level reference model.
module tb_gate_lane_arbiter;

  localparam int NL   = 2;
  localparam int TM   = 50;
  localparam int TP   = 200;
  localparam int TMAX = (TM > TP) ? TM : TP;

  localparam int P_IDLE = 0, P_OPEN = 1, P_UP = 2, P_PASS = 3, P_CLOSE = 4, P_FAULT = 5;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [NL-1:0] solicitud = '0, bloqueo = '0;
  logic          sensor_abierta = 1'b0, sensor_cerrada = 1'b0, sensor_paso = 1'b0;
  logic [NL-1:0] concesion, fin_paso;
  logic          motor_abrir, motor_cerrar, falla_motor;

  int n_cmp = 0;
  int n_bad = 0;

  int m_phase = P_IDLE, m_t = 0, m_ptr = 0, m_g = 0;
  bit m_fin = 0;

  gate_lane_arbiter #(.N_CARRILES(NL), .T_MOTOR(TM), .T_PASO(TP)) dut (
    .clock          (clock),
    .reset          (reset),
    .solicitud      (solicitud),
    .bloqueo        (bloqueo),
    .sensor_abierta (sensor_abierta),
    .sensor_cerrada (sensor_cerrada),
    .sensor_paso    (sensor_paso),
    .concesion      (concesion),
    .motor_abrir    (motor_abrir),
    .motor_cerrar   (motor_cerrar),
    .fin_paso       (fin_paso),
    .falla_motor    (falla_motor)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock of the reference: inputs as seen at this edge decide the next phase.
  task automatic model_step();
    int nxt;
    int elig;
    nxt   = m_phase;
    m_fin = 0;
    if (reset) begin
      m_phase = P_IDLE; m_t = 0; m_ptr = 0;
      return;
    end
    case (m_phase)
      P_IDLE: begin
        elig = int'(solicitud & ~bloqueo);
        if (elig != 0) begin
          for (int k = 0; k < NL; k++) begin
            if (((elig >> ((m_ptr + k) % NL)) & 1) != 0) begin
              m_g = (m_ptr + k) % NL;
              break;
            end
          end
          nxt = P_OPEN;
        end
      end
      P_OPEN: begin
        if (sensor_abierta && sensor_cerrada) nxt = P_FAULT;
        else if (sensor_abierta)              nxt = P_UP;
        else if (m_t == TM - 1)               nxt = P_FAULT;
      end
      P_UP: begin
        if (sensor_paso)         nxt = P_PASS;
        else if (m_t == TP - 1)  nxt = P_CLOSE;
      end
      P_PASS: begin
        if (!sensor_paso) begin nxt = P_CLOSE; m_fin = 1; end
      end
      P_CLOSE: begin
        if (sensor_abierta && sensor_cerrada) nxt = P_FAULT;
        else if (sensor_paso)                 nxt = P_OPEN;
        else if (sensor_cerrada) begin nxt = P_IDLE; m_ptr = (m_g + 1) % NL; end
        else if (m_t == TM - 1)               nxt = P_FAULT;
      end
      default: nxt = P_FAULT;
    endcase
    if (nxt != m_phase) m_t = 0;
    else if (m_t < TMAX) m_t++;
    m_phase = nxt;
  endtask

  task automatic compare_all();
    int exp_con;
    exp_con = (m_phase >= P_OPEN && m_phase <= P_CLOSE) ? (1 << m_g) : 0;
    check("concesion",    32'(concesion),    32'(exp_con));
    check("motor_abrir",  32'(motor_abrir),  32'(m_phase == P_OPEN));
    check("motor_cerrar", 32'(motor_cerrar), 32'(m_phase == P_CLOSE));
    check("fin_paso",     32'(fin_paso),     m_fin ? 32'(1 << m_g) : 32'd0);
    check("falla_motor",  32'(falla_motor),  32'(m_phase == P_FAULT));
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1; solicitud = '0; bloqueo = '0;
    sensor_abierta = 0; sensor_cerrada = 0; sensor_paso = 0;
    tick();
    reset = 1'b0;
  endtask

  // From ABRIENDO: open, vehicle passes, close back to REPOSO.
  task automatic run_cycle();
    sensor_abierta = 1; tick();
    sensor_abierta = 0; sensor_paso = 1; tick();
    sensor_paso = 0; tick();
    check("fin_pulse", 32'(fin_paso != 0), 32'd1);
    tick();
    check("fin_once", 32'(fin_paso), 32'd0);
    sensor_cerrada = 1; tick();
    sensor_cerrada = 0;
  endtask

  initial begin
    do_reset();
    check("rst_concesion", 32'(concesion), 32'd0);
    check("rst_falla", 32'(falla_motor), 32'd0);

    // Reset mid-ABRIENDO, pointer returns to lane 0
    solicitud = 2'b01; tick(); run_cycle(); solicitud = 2'b11; tick();
    check("t1_pre_grant", 32'(concesion), 32'h2);
    ticks(3);
    reset = 1; tick(); reset = 0;
    check("t1_motor_off", 32'(motor_abrir), 32'd0);
    check("t1_no_grant", 32'(concesion), 32'd0);
    tick();
    check("t1_ptr0", 32'(concesion), 32'h1);
    do_reset();

    // Alternating grants with both lanes requesting
    solicitud = 2'b11; tick();
    check("t2_g0", 32'(concesion), 32'h1);
    run_cycle(); tick();
    check("t2_g1", 32'(concesion), 32'h2);
    run_cycle(); tick();
    check("t2_g2", 32'(concesion), 32'h1);
    run_cycle();
    do_reset();

    // Locked lane masked until lock clears
    solicitud = 2'b01; bloqueo = 2'b01; ticks(3);
    check("t3_blocked", 32'(concesion), 32'd0);
    bloqueo = 2'b00; tick();
    check("t3_granted", 32'(concesion), 32'h1);
    run_cycle(); solicitud = '0; tick();
    do_reset();

    // Safety reopen while closing
    solicitud = 2'b10; tick();
    sensor_abierta = 1; tick(); sensor_abierta = 0;
    sensor_paso = 1; tick(); sensor_paso = 0; tick();
    check("t4_closing", 32'(motor_cerrar), 32'd1);
    sensor_paso = 1; tick();
    check("t4_reopen_abrir", 32'(motor_abrir), 32'd1);
    check("t4_reopen_cerrar", 32'(motor_cerrar), 32'd0);
    check("t4_grant_kept", 32'(concesion), 32'h2);
    sensor_paso = 0; solicitud = '0; run_cycle();
    do_reset();

    // Open travel timeout -> sticky fault
    solicitud = 2'b01; tick(); ticks(TM - 1);
    check("t5_pre_fault", 32'(falla_motor), 32'd0);
    tick();
    check("t5_fault", 32'(falla_motor), 32'd1);
    solicitud = 2'b11; ticks(20);
    check("t5_sticky", 32'(falla_motor), 32'd1);
    check("t5_no_grant", 32'(concesion), 32'd0);
    do_reset();
    check("t5_cleared", 32'(falla_motor), 32'd0);

    // Vehicle never arrives -> auto-close without fin_paso
    solicitud = 2'b01; tick();
    sensor_abierta = 1; tick(); sensor_abierta = 0; solicitud = '0;
    ticks(TP - 1);
    check("t6_still_open", 32'(motor_cerrar), 32'd0);
    tick();
    check("t6_closing", 32'(motor_cerrar), 32'd1);
    check("t6_no_fin", 32'(fin_paso), 32'd0);
    sensor_cerrada = 1; tick(); sensor_cerrada = 0;
    do_reset();

    // Random traffic
    for (int c = 0; c < 4000; c++) begin
      reset          = ($urandom_range(0, 99) < 2);
      solicitud      = NL'($urandom);
      bloqueo        = ($urandom_range(0, 3) == 0) ? NL'($urandom) : '0;
      sensor_abierta = ($urandom_range(0, 9) < 3);
      sensor_cerrada = (!sensor_abierta && $urandom_range(0, 9) < 3) || ($urandom_range(0, 49) == 0);
      sensor_paso    = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
